// File: rtl/ahb3lite_pkg.sv
// Shared AHB3-Lite bus constants and helpers used by masters, slaves and benches.
package ahb3lite_pkg;

    localparam int unsigned HTRANS_SIZE = 2;
    localparam int unsigned HSIZE_SIZE  = 3;
    localparam int unsigned HBURST_SIZE = 3;
    localparam int unsigned HPROT_SIZE  = 4;

    localparam logic [HTRANS_SIZE-1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [HTRANS_SIZE-1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [HTRANS_SIZE-1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [HTRANS_SIZE-1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [HSIZE_SIZE-1:0] HSIZE_BYTE  = 3'd0;
    localparam logic [HSIZE_SIZE-1:0] HSIZE_HWORD = 3'd1;
    localparam logic [HSIZE_SIZE-1:0] HSIZE_WORD  = 3'd2;
    localparam logic [HSIZE_SIZE-1:0] HSIZE_DWORD = 3'd3;
    localparam logic [HSIZE_SIZE-1:0] HSIZE_B128  = 3'd4;
    localparam logic [HSIZE_SIZE-1:0] HSIZE_B256  = 3'd5;
    localparam logic [HSIZE_SIZE-1:0] HSIZE_B512  = 3'd6;
    localparam logic [HSIZE_SIZE-1:0] HSIZE_B1024 = 3'd7;

    localparam logic [HBURST_SIZE-1:0] HBURST_SINGLE = 3'd0;
    localparam logic [HBURST_SIZE-1:0] HBURST_INCR   = 3'd1;
    localparam logic [HBURST_SIZE-1:0] HBURST_WRAP4  = 3'd2;
    localparam logic [HBURST_SIZE-1:0] HBURST_INCR4  = 3'd3;
    localparam logic [HBURST_SIZE-1:0] HBURST_WRAP8  = 3'd4;
    localparam logic [HBURST_SIZE-1:0] HBURST_INCR8  = 3'd5;
    localparam logic [HBURST_SIZE-1:0] HBURST_WRAP16 = 3'd6;
    localparam logic [HBURST_SIZE-1:0] HBURST_INCR16 = 3'd7;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    function automatic int unsigned get_bytes_per_beat(input logic [HSIZE_SIZE-1:0] hsize);
        return 32'd1 << hsize;
    endfunction

endpackage

// File: rtl/ahb3lite_sram_slave_mem.sv
// Word-addressed storage with a byte-enable synchronous write port and asynchronous read port.
// Contents are deliberately not reset.
module ahb3lite_sram_slave_mem #(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 8
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [DATA_W/8-1:0]   be_i,
    input  logic [ADDR_W-1:0]     waddr_i,
    input  logic [DATA_W-1:0]     wdata_i,
    input  logic [ADDR_W-1:0]     raddr_i,
    output logic [DATA_W-1:0]     rdata_o
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int i = 0; i < DATA_W / 8; i++) begin
                if (be_i[i]) begin
                    mem[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

    assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/ahb3lite_sram_slave.sv
// AHB3-Lite slave over an internal memory: configurable wait states, two-cycle ERROR response
// for out-of-range indices and oversize transfers.
module ahb3lite_sram_slave
    import ahb3lite_pkg::*;
#(
    parameter int unsigned HADDR_SIZE  = 16,
    parameter int unsigned HDATA_SIZE  = 32,
    parameter int unsigned MEM_DEPTH   = 256,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                   HCLK,
    input  logic                   HRESET,
    input  logic                   HSEL,
    input  logic [HADDR_SIZE-1:0]  HADDR,
    input  logic [HDATA_SIZE-1:0]  HWDATA,
    output logic [HDATA_SIZE-1:0]  HRDATA,
    input  logic                   HWRITE,
    input  logic [HSIZE_SIZE-1:0]  HSIZE,
    input  logic [HBURST_SIZE-1:0] HBURST,
    input  logic [HPROT_SIZE-1:0]  HPROT,
    input  logic [HTRANS_SIZE-1:0] HTRANS,
    input  logic                   HMASTLOCK,
    input  logic                   HREADY,
    output logic                   HREADYOUT,
    output logic                   HRESP
);

    localparam int unsigned NB     = HDATA_SIZE / 8;
    localparam int unsigned BOFF_W = $clog2(NB);
    localparam int unsigned OFF_W  = (BOFF_W > 0) ? BOFF_W : 1;
    localparam int unsigned IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int unsigned CMP_W  = HADDR_SIZE + 32;

    localparam logic [HADDR_SIZE-1:0] OFF_MASK  = HADDR_SIZE'(NB - 1);
    localparam logic [HSIZE_SIZE-1:0] MAX_HSIZE = HSIZE_SIZE'(BOFF_W);
    localparam logic [3:0]            WS_LOAD   = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    typedef enum logic [1:0] {StOkay, StWait, StErr1, StErr2} state_e;

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  pend_q, pend_d;
    logic                  write_q;
    logic [HSIZE_SIZE-1:0] size_q;
    logic [IDX_W-1:0]      idx_q;
    logic [OFF_W-1:0]      off_q;

    logic                  accept;
    logic                  req_err;
    logic [HADDR_SIZE-1:0] word_idx;
    logic [HADDR_SIZE-1:0] addr_off;
    logic [NB-1:0]         be;
    logic                  mem_we;
    logic [HDATA_SIZE-1:0] mem_rdata;
    int unsigned           bytes;
    int unsigned           off_al;
    logic                  unused_ok;

    assign accept   = HSEL & HREADY & ((HTRANS == HTRANS_NONSEQ) | (HTRANS == HTRANS_SEQ));
    assign word_idx = HADDR >> BOFF_W;
    assign addr_off = HADDR & OFF_MASK;
    assign req_err  = (CMP_W'(word_idx) >= CMP_W'(MEM_DEPTH)) | (HSIZE > MAX_HSIZE);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        HREADYOUT = 1'b1;
        HRESP     = HRESP_OKAY;
        case (state_q)
            StWait: begin
                HREADYOUT = 1'b0;
                if (cnt_q == 4'd0) state_d = StOkay;
                else               cnt_d   = cnt_q - 4'd1;
            end
            StErr1: begin
                HREADYOUT = 1'b0;
                HRESP     = HRESP_ERROR;
                state_d   = StErr2;
            end
            StErr2: begin
                HRESP   = HRESP_ERROR;
                state_d = StOkay;
            end
            default: ;
        endcase
        // A ready cycle closes the current data phase; an accept on that edge opens the next.
        if (HREADYOUT) pend_d = 1'b0;
        if (accept) begin
            pend_d = ~req_err;
            if (req_err) begin
                state_d = StErr1;
            end else if (WAIT_STATES > 0) begin
                state_d = StWait;
                cnt_d   = WS_LOAD;
            end else begin
                state_d = StOkay;
            end
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q <= StOkay;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            write_q <= 1'b0;
            size_q  <= '0;
            idx_q   <= '0;
            off_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            if (accept) begin
                write_q <= HWRITE;
                size_q  <= HSIZE;
                idx_q   <= word_idx[IDX_W-1:0];
                off_q   <= addr_off[OFF_W-1:0];
            end
        end
    end

    // Unaligned offsets are truncated down to the transfer size before forming lane enables.
    always_comb begin
        bytes  = get_bytes_per_beat(size_q);
        off_al = 32'(off_q) & ~(bytes - 32'd1);
        be     = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            if (i >= off_al && i < off_al + bytes) be[i] = 1'b1;
        end
    end

    assign mem_we = pend_q & write_q & (state_q == StOkay);
    assign HRDATA = (pend_q & ~write_q) ? mem_rdata : '0;

    ahb3lite_sram_slave_mem #(
        .DEPTH  (MEM_DEPTH),
        .DATA_W (HDATA_SIZE),
        .ADDR_W (IDX_W)
    ) u_mem (
        .clk_i   (HCLK),
        .we_i    (mem_we),
        .be_i    (be),
        .waddr_i (idx_q),
        .wdata_i (HWDATA),
        .raddr_i (idx_q),
        .rdata_o (mem_rdata)
    );

    assign unused_ok = ^{HBURST, HPROT, HMASTLOCK, addr_off};

endmodule

// File: tb/tb_ahb3lite_sram_slave.sv
// Directed bench: one zero-wait and one three-wait-state slave share the bus stimulus.
module tb_ahb3lite_sram_slave;
    import ahb3lite_pkg::*;

    logic        hclk = 1'b0;
    logic        hreset;
    logic        hsel;
    logic        use3;
    logic [15:0] haddr;
    logic [31:0] hwdata;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic [1:0]  htrans;
    logic        hmastlock;

    logic [31:0] hrdata0, hrdata3, hrdata;
    logic        ho0, ho3, hreadyout;
    logic        hresp0, hresp3, hresp;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 hclk = ~hclk;

    assign hreadyout = use3 ? ho3 : ho0;
    assign hresp     = use3 ? hresp3 : hresp0;
    assign hrdata    = use3 ? hrdata3 : hrdata0;

    ahb3lite_sram_slave #(
        .HADDR_SIZE(16), .HDATA_SIZE(32), .MEM_DEPTH(256), .WAIT_STATES(0)
    ) dut0 (
        .HCLK(hclk), .HRESET(hreset), .HSEL(hsel & ~use3), .HADDR(haddr), .HWDATA(hwdata),
        .HRDATA(hrdata0), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot),
        .HTRANS(htrans), .HMASTLOCK(hmastlock), .HREADY(ho0), .HREADYOUT(ho0), .HRESP(hresp0)
    );

    ahb3lite_sram_slave #(
        .HADDR_SIZE(16), .HDATA_SIZE(32), .MEM_DEPTH(256), .WAIT_STATES(3)
    ) dut3 (
        .HCLK(hclk), .HRESET(hreset), .HSEL(hsel & use3), .HADDR(haddr), .HWDATA(hwdata),
        .HRDATA(hrdata3), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot),
        .HTRANS(htrans), .HMASTLOCK(hmastlock), .HREADY(ho3), .HREADYOUT(ho3), .HRESP(hresp3)
    );

    typedef struct {
        bit          w;
        logic [15:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    vec_t vecs[16];

    logic [15:0] b_addr[8];
    logic [31:0] b_wdata[8];
    logic [31:0] b_rdata[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One transfer followed by an IDLE; reports data-phase cycles and not-ready cycles.
    task automatic xfer(input bit w, input logic [15:0] a, input logic [2:0] sz,
                        input logic [31:0] wd, output logic [31:0] rd, output bit err,
                        output int cyc, output int low);
        bit done;
        @(negedge hclk);
        hsel = 1'b1; htrans = HTRANS_NONSEQ; haddr = a; hwrite = w; hsize = sz;
        hburst = HBURST_SINGLE;
        @(negedge hclk);
        hsel = 1'b0; htrans = HTRANS_IDLE; hwdata = wd;
        cyc = 0; low = 0; err = 1'b0; rd = '0; done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            cyc++;
            if (hresp) err = 1'b1;
            if (hreadyout) begin
                rd   = hrdata;
                done = 1'b1;
            end else begin
                low++;
                @(negedge hclk);
            end
        end
        check("xfer_done", 32'(done), 32'd1);
    endtask

    // Pipelined word burst over b_addr; stalls while the slave is not ready.
    task automatic burst(input bit w, input int n, input logic [2:0] hb,
                         output int cyc, output int low);
        cyc = 0; low = 0;
        for (int i = 0; i <= n; i++) begin
            @(negedge hclk);
            if (i < n) begin
                hsel = 1'b1; htrans = (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ;
                haddr = b_addr[i]; hwrite = w; hsize = HSIZE_WORD; hburst = hb;
            end else begin
                hsel = 1'b0; htrans = HTRANS_IDLE;
            end
            if (i > 0) hwdata = b_wdata[i-1];
            cyc++;
            if (i > 0) begin
                for (int k = 0; k < 40 && !hreadyout; k++) begin
                    low++;
                    @(negedge hclk);
                    cyc++;
                end
                b_rdata[i-1] = hrdata;
            end
        end
    endtask

    logic [31:0] rd;
    bit          err;
    int          cyc, low;

    initial begin
        hreset = 1'b1; hsel = 1'b0; use3 = 1'b0; haddr = '0; hwdata = '0; hwrite = 1'b0;
        hsize = HSIZE_WORD; hburst = HBURST_SINGLE; hprot = 4'b0011; htrans = HTRANS_IDLE;
        hmastlock = 1'b0;

        vecs[0]  = '{1'b1, 16'h0010, HSIZE_WORD,  32'hDEADBEEF, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 16'h0010, HSIZE_WORD,  32'h0,        32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 16'h0010, HSIZE_WORD,  32'h11223344, 32'h0,        1'b0};
        vecs[3]  = '{1'b1, 16'h0013, HSIZE_BYTE,  32'hAA000000, 32'h0,        1'b0};
        vecs[4]  = '{1'b0, 16'h0010, HSIZE_WORD,  32'h0,        32'hAA223344, 1'b0};
        vecs[5]  = '{1'b1, 16'h0014, HSIZE_WORD,  32'h00000000, 32'h0,        1'b0};
        vecs[6]  = '{1'b1, 16'h0016, HSIZE_HWORD, 32'h55660000, 32'h0,        1'b0};
        vecs[7]  = '{1'b0, 16'h0014, HSIZE_WORD,  32'h0,        32'h55660000, 1'b0};
        vecs[8]  = '{1'b1, 16'h0018, HSIZE_WORD,  32'hFFFFFFFF, 32'h0,        1'b0};
        vecs[9]  = '{1'b1, 16'h0019, HSIZE_HWORD, 32'h00001234, 32'h0,        1'b0};
        vecs[10] = '{1'b0, 16'h0018, HSIZE_WORD,  32'h0,        32'hFFFF1234, 1'b0};
        vecs[11] = '{1'b1, 16'h0000, HSIZE_WORD,  32'h01020304, 32'h0,        1'b0};
        vecs[12] = '{1'b1, 16'h0400, HSIZE_WORD,  32'hBADBAD00, 32'h0,        1'b1};
        vecs[13] = '{1'b1, 16'h0000, HSIZE_DWORD, 32'hBADBAD11, 32'h0,        1'b1};
        vecs[14] = '{1'b1, 16'h03FC, HSIZE_WORD,  32'hCAFEF00D, 32'h0,        1'b0};
        vecs[15] = '{1'b0, 16'h0000, HSIZE_WORD,  32'h0,        32'h01020304, 1'b0};

        repeat (2) @(negedge hclk);
        check("reset_hreadyout0", 32'(ho0), 32'd1);
        check("reset_hreadyout3", 32'(ho3), 32'd1);
        check("reset_hresp0", 32'(hresp0), 32'd0);
        check("reset_hrdata0", hrdata0, 32'h0);
        hreset = 1'b0;

        for (int v = 0; v < 16; v++) begin
            xfer(vecs[v].w, vecs[v].addr, vecs[v].size, vecs[v].wdata, rd, err, cyc, low);
            check($sformatf("vec%0d_resp", v), 32'(err), 32'(vecs[v].exp_err));
            check($sformatf("vec%0d_cycles", v), 32'(cyc), vecs[v].exp_err ? 32'd2 : 32'd1);
            if (!vecs[v].w) check($sformatf("vec%0d_rdata", v), rd, vecs[v].exp_rdata);
        end
        xfer(1'b0, 16'h03FC, HSIZE_WORD, 32'h0, rd, err, cyc, low);
        check("last_word_rdata", rd, 32'hCAFEF00D);

        // INCR4 writes at 0x20 and 0x30, then a WRAP8 read starting at 0x38.
        for (int i = 0; i < 4; i++) begin
            b_addr[i]  = 16'h0020 + 16'(4 * i);
            b_wdata[i] = 32'hA0000000 | 32'(b_addr[i]);
        end
        burst(1'b1, 4, HBURST_INCR4, cyc, low);
        check("incr4_cycles", 32'(cyc), 32'd5);
        check("incr4_ready_low", 32'(low), 32'd0);
        for (int i = 0; i < 4; i++) begin
            b_addr[i]  = 16'h0030 + 16'(4 * i);
            b_wdata[i] = 32'hA0000000 | 32'(b_addr[i]);
        end
        burst(1'b1, 4, HBURST_INCR4, cyc, low);
        for (int i = 0; i < 8; i++) begin
            b_addr[i]  = 16'h0020 + 16'((4 * i + 16'h18) % 32);
            b_wdata[i] = '0;
        end
        burst(1'b0, 8, HBURST_WRAP8, cyc, low);
        check("wrap8_cycles", 32'(cyc), 32'd9);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("wrap8_beat%0d", i), b_rdata[i],
                  32'hA0000000 | 32'(16'h0020 + 16'((4 * i + 16'h18) % 32)));
        end

        // Write then read of the same word back to back.
        @(negedge hclk);
        hsel = 1'b1; htrans = HTRANS_NONSEQ; haddr = 16'h0040; hwrite = 1'b1;
        hsize = HSIZE_WORD; hburst = HBURST_SINGLE;
        @(negedge hclk);
        hwrite = 1'b0; hwdata = 32'h13579BDF;
        check("b2b_write_ready", 32'(hreadyout), 32'd1);
        @(negedge hclk);
        hsel = 1'b0; htrans = HTRANS_IDLE;
        check("b2b_read_ready", 32'(hreadyout), 32'd1);
        check("b2b_read_data", hrdata, 32'h13579BDF);

        // Three wait states.
        use3 = 1'b1;
        xfer(1'b1, 16'h0010, HSIZE_WORD, 32'h0BADF00D, rd, err, cyc, low);
        check("ws3_write_cycles", 32'(cyc), 32'd4);
        xfer(1'b0, 16'h0010, HSIZE_WORD, 32'h0, rd, err, cyc, low);
        check("ws3_read_cycles", 32'(cyc), 32'd4);
        check("ws3_read_low", 32'(low), 32'd3);
        check("ws3_read_resp", 32'(err), 32'd0);
        check("ws3_read_data", rd, 32'h0BADF00D);

        // Reset in the middle of a waited write discards it.
        xfer(1'b1, 16'h0050, HSIZE_WORD, 32'h11111111, rd, err, cyc, low);
        @(negedge hclk);
        hsel = 1'b1; htrans = HTRANS_NONSEQ; haddr = 16'h0050; hwrite = 1'b1;
        @(negedge hclk);
        hsel = 1'b0; htrans = HTRANS_IDLE; hwdata = 32'h22222222;
        check("rst_wait_low", 32'(hreadyout), 32'd0);
        #2 hreset = 1'b1;
        #1;
        check("rst_async_ready", 32'(hreadyout), 32'd1);
        check("rst_async_resp", 32'(hresp), 32'd0);
        @(negedge hclk);
        hreset = 1'b0;
        @(negedge hclk);
        check("rst_release_ready", 32'(hreadyout), 32'd1);
        xfer(1'b0, 16'h0050, HSIZE_WORD, 32'h0, rd, err, cyc, low);
        check("rst_word_unchanged", rd, 32'h11111111);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
